// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the multicycle CPU's unified memory port.
package cpu_mem_pkg;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 32;
  localparam int MEM_DEPTH = 10;

  // IorD mux select toward memory
  localparam logic IORD_PC  = 1'b0;
  localparam logic IORD_ALU = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPT,
    WR,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_FETCH,
    OP_LOAD,
    OP_STORE
  } op_e;

endpackage

// File: rtl/mem_port_master.sv
// Initiator for the unified instruction/data memory: a read completes 3 edges after acceptance, a store 2.
// Requests are sampled only in IDLE; anything presented while busy is high is dropped.
module mem_port_master
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W    = cpu_mem_pkg::DATA_W,
  parameter int ADDR_W    = cpu_mem_pkg::ADDR_W,
  parameter int MEM_DEPTH = cpu_mem_pkg::MEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic              ld_req,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              busy,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic [DATA_W-1:0] mdr,
  output logic              mdr_valid,
  output logic              st_done,
  output logic              addr_err,
  output logic [ADDR_W-1:0] pc_address,
  output logic [ADDR_W-1:0] alu_address,
  output logic [DATA_W-1:0] data_in,
  output logic              we,
  output logic              IorD,
  output logic              memread,
  input  logic [DATA_W-1:0] mem_data_out
);

  state_e            state_q;
  op_e               op_q;
  logic              oor_q;
  logic              busy_q;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] mdr_q;
  logic              ir_valid_q;
  logic              mdr_valid_q;
  logic              st_done_q;
  logic              addr_err_q;
  logic [ADDR_W-1:0] pc_address_q;
  logic [ADDR_W-1:0] alu_address_q;
  logic [DATA_W-1:0] data_in_q;
  logic              we_q;
  logic              iord_q;
  logic              memread_q;

  logic              pc_oor_d;
  logic              addr_oor_d;
  logic [DATA_W-1:0] capt_d;

  always_comb begin
    pc_oor_d   = (pc >= ADDR_W'(MEM_DEPTH));
    addr_oor_d = (addr >= ADDR_W'(MEM_DEPTH));
    // An out-of-range read never reached memory, so its result is forced to zero.
    capt_d     = oor_q ? '0 : mem_data_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      op_q          <= OP_FETCH;
      oor_q         <= 1'b0;
      busy_q        <= 1'b0;
      ir_q          <= '0;
      mdr_q         <= '0;
      ir_valid_q    <= 1'b0;
      mdr_valid_q   <= 1'b0;
      st_done_q     <= 1'b0;
      addr_err_q    <= 1'b0;
      pc_address_q  <= '0;
      alu_address_q <= '0;
      data_in_q     <= '0;
      we_q          <= 1'b0;
      iord_q        <= IORD_PC;
      memread_q     <= 1'b0;
    end else begin
      ir_valid_q  <= 1'b0;
      mdr_valid_q <= 1'b0;
      st_done_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (st_req) begin
            // A simultaneous load is dropped and flagged as an error.
            op_q          <= OP_STORE;
            oor_q         <= addr_oor_d;
            busy_q        <= 1'b1;
            alu_address_q <= addr;
            data_in_q     <= st_data;
            iord_q        <= IORD_ALU;
            we_q          <= !addr_oor_d;
            if (addr_oor_d || ld_req) addr_err_q <= 1'b1;
            state_q       <= WR;
          end else if (ld_req) begin
            op_q          <= OP_LOAD;
            oor_q         <= addr_oor_d;
            busy_q        <= 1'b1;
            alu_address_q <= addr;
            iord_q        <= IORD_ALU;
            memread_q     <= !addr_oor_d;
            if (addr_oor_d) addr_err_q <= 1'b1;
            state_q       <= RD_ISSUE;
          end else if (fetch_req) begin
            op_q          <= OP_FETCH;
            oor_q         <= pc_oor_d;
            busy_q        <= 1'b1;
            pc_address_q  <= pc;
            iord_q        <= IORD_PC;
            memread_q     <= !pc_oor_d;
            if (pc_oor_d) addr_err_q <= 1'b1;
            state_q       <= RD_ISSUE;
          end
        end
        RD_ISSUE: begin
          memread_q <= 1'b0;
          state_q   <= RD_CAPT;
        end
        RD_CAPT: begin
          if (op_q == OP_FETCH) begin
            ir_q       <= capt_d;
            ir_valid_q <= 1'b1;
          end else begin
            mdr_q       <= capt_d;
            mdr_valid_q <= 1'b1;
          end
          state_q <= DONE;
        end
        WR: begin
          we_q      <= 1'b0;
          st_done_q <= 1'b1;
          state_q   <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign ir          = ir_q;
  assign ir_valid    = ir_valid_q;
  assign mdr         = mdr_q;
  assign mdr_valid   = mdr_valid_q;
  assign st_done     = st_done_q;
  assign addr_err    = addr_err_q;
  assign pc_address  = pc_address_q;
  assign alu_address = alu_address_q;
  assign data_in     = data_in_q;
  assign we          = we_q;
  assign IorD        = iord_q;
  assign memread     = memread_q;

endmodule

// File: tb/tb_mem_port_master.sv
// Bench for mem_port_master with a registered-read memory model and a completion scoreboard.
module tb_mem_port_master;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int DEPTH = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fetch_req = 1'b0, ld_req = 1'b0, st_req = 1'b0;
  logic [AW-1:0] pc = '0, addr = '0;
  logic [DW-1:0] st_data = '0;
  logic          busy, ir_valid, mdr_valid, st_done, addr_err, we, IorD, memread;
  logic [DW-1:0] ir, mdr, data_in, mem_data_out;
  logic [AW-1:0] pc_address, alu_address;

  mem_port_master #(.DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .ld_req(ld_req), .st_req(st_req),
    .pc(pc), .addr(addr), .st_data(st_data),
    .busy(busy), .ir(ir), .ir_valid(ir_valid), .mdr(mdr), .mdr_valid(mdr_valid),
    .st_done(st_done), .addr_err(addr_err),
    .pc_address(pc_address), .alu_address(alu_address), .data_in(data_in),
    .we(we), .IorD(IorD), .memread(memread), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Memory model: synchronous write, registered read.
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] mem_a;
  initial begin
    mem[0] = 32'h0022_1800;
    mem[1] = 32'h0022_1801;
    mem[2] = 32'h0022_1810;
    for (int i = 3; i < DEPTH; i++) mem[i] = 32'h100 + i;
    mem_data_out = '0;
  end
  assign mem_a = IorD ? alu_address : pc_address;
  always @(posedge clk) begin
    if (we && mem_a < AW'(DEPTH)) mem[mem_a] <= data_in;
    if (memread && mem_a < AW'(DEPTH)) mem_data_out <= mem[mem_a];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0]    kind;   // 0 ir, 1 mdr, 2 store
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  int rd_cycles = 0, wr_cycles = 0;
  int exp_rd = 0, exp_wr = 0;

  // Completion monitor: every pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (memread) rd_cycles++;
      if (we) wr_cycles++;
      if (ir_valid || mdr_valid || st_done) begin
        exp_t e;
        logic [1:0] k;
        logic [DW-1:0] d;
        k = ir_valid ? 2'd0 : (mdr_valid ? 2'd1 : 2'd2);
        d = ir_valid ? ir : (mdr_valid ? mdr : '0);
        if (sb.size() == 0) begin
          check("unexpected_pulse", {62'd0, k}, 64'd3);
        end else begin
          e = sb.pop_front();
          check("pulse_kind", {62'd0, k}, {62'd0, e.kind});
          check("pulse_data", {32'd0, d}, {32'd0, e.data});
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Present a request for one cycle; returns at the negedge after the accepting edge.
  task automatic issue(input logic f, input logic l, input logic s,
                       input logic [AW-1:0] p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    step();
    fetch_req = f; ld_req = l; st_req = s; pc = p; addr = a; st_data = d;
    step();
    fetch_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 10) begin
      step();
      n++;
    end
    if (busy) check("busy_timeout", 64'd1, 64'd0);
  endtask

  task automatic push(input logic [1:0] k, input logic [DW-1:0] d);
    exp_t e;
    e.kind = k;
    e.data = d;
    sb.push_back(e);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_ir", ir, 0);
    check("rst_mdr", mdr, 0);
    check("rst_addr_err", addr_err, 0);
    check("rst_ctrl", {memread, we, IorD, ir_valid, mdr_valid, st_done}, 0);
    check("rst_addrs", {pc_address, alu_address}, 0);
    check("rst_data_in", data_in, 0);
    rst = 1'b0;

    // Fetch pc=0 with cycle-by-cycle timing
    push(0, 32'h0022_1800); exp_rd++;
    issue(1, 0, 0, 0, 0, 0);
    check("f0_e0_busy", busy, 1);
    check("f0_e0_memread", memread, 1);
    check("f0_e0_iord", IorD, 0);
    check("f0_e0_pc_address", pc_address, 0);
    step();
    check("f0_e1_memread", memread, 0);
    check("f0_e1_valid", ir_valid, 0);
    step();
    check("f0_e2_ir_valid", ir_valid, 1);
    check("f0_e2_busy", busy, 1);
    step();
    check("f0_e3_ir_valid", ir_valid, 0);
    check("f0_e3_busy", busy, 0);

    // Fetches pc=1, pc=2
    push(0, 32'h0022_1801); exp_rd++;
    issue(1, 0, 0, 1, 0, 0);
    check("f1_iord", IorD, 0);
    wait_idle();
    push(0, 32'h0022_1810); exp_rd++;
    issue(1, 0, 0, 2, 0, 0);
    wait_idle();
    check("f2_ir", ir, 32'h0022_1810);

    // Store then load back
    push(2, 0); exp_wr++;
    issue(0, 0, 1, 0, 5, 32'hDEAD_BEEF);
    check("st_we", we, 1);
    check("st_iord", IorD, 1);
    check("st_memread", memread, 0);
    check("st_alu_address", alu_address, 5);
    check("st_data_in", data_in, 32'hDEAD_BEEF);
    step();
    check("st_we_drop", we, 0);
    check("st_done", st_done, 1);
    wait_idle();
    push(1, 32'hDEAD_BEEF); exp_rd++;
    issue(0, 1, 0, 0, 5, 0);
    check("ld_iord", IorD, 1);
    wait_idle();
    check("ld_mdr", mdr, 32'hDEAD_BEEF);

    // Load wins over fetch; fetch served only once re-requested
    push(1, 32'h0022_1801); exp_rd++;
    issue(1, 1, 0, 0, 1, 0);
    wait_idle();
    step(); step();
    check("lf_ir_hold", ir, 32'h0022_1810);
    push(0, 32'h0022_1800); exp_rd++;
    issue(1, 0, 0, 0, 0, 0);
    wait_idle();

    // Out-of-range load
    check("oor_err_before", addr_err, 0);
    push(1, 0);
    issue(0, 1, 0, 0, 10, 0);
    check("oor_memread", memread, 0);
    wait_idle();
    check("oor_mdr", mdr, 0);
    check("oor_err", addr_err, 1);
    step(); step();
    check("oor_err_sticky", addr_err, 1);

    // Requests while busy are ignored
    push(0, 32'h0022_1810); exp_rd++;
    issue(1, 0, 0, 2, 0, 0);
    ld_req = 1'b1; st_req = 1'b1; addr = 3; st_data = 32'hBAD0_BAD0;
    step(); step();
    ld_req = 1'b0; st_req = 1'b0;
    wait_idle();
    step(); step(); step();
    check("busy_idle_after", busy, 0);

    // Reset during RD_CAPT of a fetch at pc=1
    exp_rd++;
    issue(1, 0, 0, 1, 0, 0);
    step();
    rst = 1'b1;
    step();
    check("rr_ir_valid", ir_valid, 0);
    check("rr_ir", ir, 0);
    check("rr_busy", busy, 0);
    check("rr_ctrl", {memread, we, IorD}, 0);
    check("rr_pc_address", pc_address, 0);
    check("rr_addr_err", addr_err, 0);
    rst = 1'b0;

    // Store and load together: store served, load dropped, error flagged
    push(2, 0); exp_wr++;
    issue(0, 1, 1, 0, 3, 32'h1234_5678);
    wait_idle();
    check("sl_addr_err", addr_err, 1);
    push(1, 32'h1234_5678); exp_rd++;
    issue(0, 1, 0, 0, 3, 0);
    wait_idle();
    check("sl_mdr", mdr, 32'h1234_5678);

    step(); step();
    check("memread_cycles", rd_cycles, exp_rd);
    check("we_cycles", wr_cycles, exp_wr);
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
